// File: rtl/i2s_tx_if.sv
// Sample handshake and I2S output bundle for i2s_tx_serializer.
// The DUT side is the slave modport; the sample source and the bus monitor use the master modport.
interface i2s_tx_if #(
  parameter int PKT_WIDTH = 16
);
  logic [PKT_WIDTH-1:0] pkt_i;
  logic                 pktChanged_i;
  logic                 ws_o;
  logic                 sd_o;
  logic                 frameStart_o;
  logic                 underrun_o;
  logic                 overrun_o;

  modport master (
    output pkt_i, pktChanged_i,
    input  ws_o, sd_o, frameStart_o, underrun_o, overrun_o
  );

  modport slave (
    input  pkt_i, pktChanged_i,
    output ws_o, sd_o, frameStart_o, underrun_o, overrun_o
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Mono-to-stereo I2S transmitter: holds the latest sample and sends it MSB-first in both slots.
// Optional I2S_TX_MUTE_ON_UNDERRUN_EN: an underrun frame is sent as silence instead of a repeat.
module i2s_tx_serializer #(
  parameter int PKT_WIDTH  = 16,
  parameter int SLOT_WIDTH = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  i2s_tx_if.slave   bus
);
  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int CW    = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_SLOT = CW'(SLOT_WIDTH);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ws_q, ws_d;
  logic [FRAME-1:0]     shreg_q, shreg_d;
  logic [PKT_WIDTH-1:0] hold_q, hold_d;
  logic                 pending_q, pending_d;
  logic                 frame_start_q, frame_start_d;
  logic                 underrun_q, underrun_d;
  logic                 overrun_q, overrun_d;

  logic                  load;
  logic                  strobe;
  logic [PKT_WIDTH-1:0]  src;
  logic [SLOT_WIDTH-1:0] slot_w;

  assign load   = (cnt_q == '0);
  assign strobe = bus.pktChanged_i;

  always_comb begin
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    src = pending_q ? hold_q : '0;
`else
    src = hold_q;
`endif
    // Sample left-justified in its slot, trailing bits zero.
    slot_w = '0;
    slot_w[SLOT_WIDTH-1 -: PKT_WIDTH] = src;
  end

  always_comb begin
    cnt_d         = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    ws_d          = (cnt_d >= CNT_SLOT);
    shreg_d       = load ? {slot_w, slot_w} : {shreg_q[FRAME-2:0], 1'b0};
    hold_d        = strobe ? bus.pkt_i : hold_q;
    // A strobe on the load edge re-arms pending for the following frame.
    pending_d     = strobe | (pending_q & ~load);
    frame_start_d = load;
    underrun_d    = load & ~pending_q;
    overrun_d     = strobe & pending_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= '0;
      ws_q          <= 1'b0;
      shreg_q       <= '0;
      hold_q        <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      ws_q          <= ws_d;
      shreg_q       <= shreg_d;
      hold_q        <= hold_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.ws_o         = ws_q;
  assign bus.sd_o         = shreg_q[FRAME-1];
  assign bus.frameStart_o = frame_start_q;
  assign bus.underrun_o   = underrun_q;
  assign bus.overrun_o    = overrun_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: 16-bit slots via a vector table, 24-bit slots by hand.
module tb_i2s_tx_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if #(.PKT_WIDTH(16)) b16 ();
  i2s_tx_if #(.PKT_WIDTH(16)) b24 ();

  i2s_tx_serializer #(.PKT_WIDTH(16), .SLOT_WIDTH(16)) u16 (.clk_i(clk), .rst_i(rst), .bus(b16));
  i2s_tx_serializer #(.PKT_WIDTH(16), .SLOT_WIDTH(24)) u24 (.clk_i(clk), .rst_i(rst), .bus(b24));

  typedef struct {
    int          c;        // cnt value of the cycle carrying the first strobe
    int          n;        // number of back-to-back strobes (0..2)
    logic [15:0] d1;
    logic [15:0] d2;
    logic [31:0] exp_def;  // frame expected, repeat-on-underrun build
    logic [31:0] exp_mute; // frame expected, mute-on-underrun build
    int          und;
    int          ovr;
  } vec_t;

  vec_t vecs [11];

  int total = 0, bad = 0;
  int tcnt = 0, tcnt24 = 0, stepno = 0;
  int und_cnt = 0, ovr_cnt = 0;
  int fs24_prev = -1, period24 = 0;
  logic [31:0] cur = '0, last = '0;
  logic [47:0] cur24 = '0, last24 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge; the bench tracks cnt itself and checks ws/frameStart every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    stepno++;
    tcnt   = (tcnt + 1) % 32;
    tcnt24 = (tcnt24 + 1) % 48;
    cur   = {cur[30:0], b16.sd_o};
    cur24 = {cur24[46:0], b24.sd_o};
    if (tcnt == 0)   last   = cur;
    if (tcnt24 == 0) last24 = cur24;
    chk("ws16",  64'(b16.ws_o),         64'(tcnt >= 16));
    chk("fs16",  64'(b16.frameStart_o), 64'(tcnt == 1));
    chk("ws24",  64'(b24.ws_o),         64'(tcnt24 >= 24));
    chk("fs24",  64'(b24.frameStart_o), 64'(tcnt24 == 1));
    if (b24.frameStart_o) begin
      if (fs24_prev >= 0) period24 = stepno - fs24_prev;
      fs24_prev = stepno;
    end
    und_cnt += int'(b16.underrun_o);
    ovr_cnt += int'(b16.overrun_o);
    b16.pktChanged_i = 1'b0;
    b24.pktChanged_i = 1'b0;
  endtask

  task automatic strobe16(input logic [15:0] d);
    b16.pkt_i = d;
    b16.pktChanged_i = 1'b1;
    step();
  endtask

  initial begin
    logic        loaded;
    logic [31:0] exp;

    vecs[0]  = '{10, 1, 16'hA5C3, 16'h0000, 32'hA5C3A5C3, 32'hA5C3A5C3, 1, 0};
    vecs[1]  = '{ 0, 1, 16'h8001, 16'h0000, 32'hA5C3A5C3, 32'h00000000, 1, 0};
    vecs[2]  = '{ 0, 0, 16'h0000, 16'h0000, 32'h80018001, 32'h80018001, 0, 0};
    vecs[3]  = '{ 5, 2, 16'h1111, 16'h2222, 32'h22222222, 32'h22222222, 1, 1};
    vecs[4]  = '{ 3, 1, 16'h7FFF, 16'h0000, 32'h7FFF7FFF, 32'h7FFF7FFF, 1, 0};
    vecs[5]  = '{ 0, 0, 16'h0000, 16'h0000, 32'h7FFF7FFF, 32'h00000000, 1, 0};
    vecs[6]  = '{ 0, 0, 16'h0000, 16'h0000, 32'h7FFF7FFF, 32'h00000000, 1, 0};
    vecs[7]  = '{ 0, 0, 16'h0000, 16'h0000, 32'h7FFF7FFF, 32'h00000000, 1, 0};
    vecs[8]  = '{31, 1, 16'h1234, 16'h0000, 32'h12341234, 32'h12341234, 1, 0};
    vecs[9]  = '{31, 2, 16'hCAFE, 16'hBEEF, 32'hCAFECAFE, 32'hCAFECAFE, 1, 1};
    vecs[10] = '{ 0, 0, 16'h0000, 16'h0000, 32'hBEEFBEEF, 32'hBEEFBEEF, 0, 0};

    b16.pkt_i = '0; b16.pktChanged_i = 1'b0;
    b24.pkt_i = '0; b24.pktChanged_i = 1'b0;

    #12;
    chk("reset16", 64'({b16.ws_o, b16.sd_o, b16.frameStart_o, b16.underrun_o, b16.overrun_o}), 64'd0);
    chk("reset24", 64'({b24.ws_o, b24.sd_o, b24.frameStart_o, b24.underrun_o, b24.overrun_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tcnt = 0; tcnt24 = 0;

    for (int i = 0; i < 11; i++) begin
      und_cnt = 0; ovr_cnt = 0;
      loaded = 1'b0;
      if (vecs[i].n > 0) begin
        while (tcnt != vecs[i].c) step();
        if (tcnt == 0) loaded = 1'b1;
        strobe16(vecs[i].d1);
        if (vecs[i].n > 1) begin
          if (tcnt == 0) loaded = 1'b1;
          strobe16(vecs[i].d2);
        end
      end
      if (!loaded) begin
        while (tcnt != 0) step();
        step();
      end
      while (tcnt != 0) step();
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
      exp = vecs[i].exp_mute;
`else
      exp = vecs[i].exp_def;
`endif
      chk($sformatf("frame[%0d]", i),     64'(last),    64'(exp));
      chk($sformatf("underruns[%0d]", i), 64'(und_cnt), 64'(vecs[i].und));
      chk($sformatf("overruns[%0d]", i),  64'(ovr_cnt), 64'(vecs[i].ovr));
    end

    // Reset mid-frame while the line is carrying ones in the right slot.
    while (tcnt != 5) step();
    strobe16(16'hFFFF);
    while (tcnt != 0) step();
    step();
    while (tcnt != 20) step();
    chk("pre_rst_ws_sd", 64'({b16.ws_o, b16.sd_o}), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst16", 64'({b16.ws_o, b16.sd_o, b16.frameStart_o, b16.underrun_o, b16.overrun_o}), 64'd0);
    chk("async_rst24", 64'({b24.ws_o, b24.sd_o, b24.frameStart_o, b24.underrun_o, b24.overrun_o}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tcnt = 0; tcnt24 = 0; fs24_prev = -1;
    step();
    chk("first_edge_fs",  64'(b16.frameStart_o), 64'd1);
    chk("first_edge_und", 64'(b16.underrun_o),   64'd1);
    chk("first_edge_sd",  64'(b16.sd_o),         64'd0);

    // 24-bit slots: 16 sample bits then 8 zero bits per slot, 48-clock frame.
    while (tcnt24 != 5) step();
    b24.pkt_i = 16'hFFFF;
    b24.pktChanged_i = 1'b1;
    step();
    while (tcnt24 != 0) step();
    step();
    while (tcnt24 != 0) step();
    chk("frame24",  64'(last24),  64'h0000_FFFF00_FFFF00);
    chk("period24", 64'(period24), 64'd48);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Serializes mono 16-bit DSP output samples onto an I2S output bus, driven by the I2S bit clock. It takes each sample with its one-cycle strobe from the TX clock-domain-crossing FIFO and holds it. At every frame boundary it sends the held sample MSB-first on both the left and right channels, in standard I2S format (one-bit delay after each word-select edge). It flags underruns and overruns on the sample handshake.

## Interface
- PKT_WIDTH, 16, sample width in bits (signed two's complement).
- SLOT_WIDTH, 16, bit clocks per channel slot; must be ≥ PKT_WIDTH; frame length = 2·SLOT_WIDTH clocks.
- clk_i  input  1  I2S bit clock (1.4112 MHz nominal); the only clock.
- rst_i  input  1  asynchronous, active-high reset.
- pkt_i  input  PKT_WIDTH  sample to transmit.
- pktChanged_i  input  1  one-cycle strobe: pkt_i is valid this cycle.
- ws_o  output  1  I2S word select: 0 = left slot, 1 = right slot.
- sd_o  output  1  I2S serial data.
- frameStart_o  output  1  one-cycle pulse on each frame-load edge.
- underrun_o  output  1  one-cycle pulse: a frame was loaded with no new sample pending.
- overrun_o  output  1  one-cycle pulse: a strobe arrived while the previous sample was still pending.

## Operation
- Frame counter cnt runs 0 … 2·SLOT_WIDTH−1 and wraps to 0. It is free-running; there is no idle state.
- Holding register hold, PKT_WIDTH bits:
  - Captures pkt_i on every cycle where pktChanged_i = 1.
  - Sets pending = 1 on capture.
- Frame load happens on the edge where cnt goes 0 → 1:
  - Frame word = {hold, zeros(SLOT_WIDTH−PKT_WIDTH), hold, zeros(SLOT_WIDTH−PKT_WIDTH)}; samples are left-justified in each slot.
  - The frame word is loaded into shift register shreg (2·SLOT_WIDTH bits).
  - pending is cleared.
  - frameStart_o pulses.
  - If pending was 0, underrun_o also pulses.
- On all other edges, shreg shifts left by 1 with zero fill.
- sd_o = shreg MSB.
  - The left-slot MSB appears when cnt = 1.
  - The right-slot LSB appears when cnt = 0 of the following frame.
- ws_o = 1 exactly when cnt ∈ [SLOT_WIDTH, 2·SLOT_WIDTH−1], registered together with cnt. ws_o therefore changes one clock before each slot MSB.
- Strobe coinciding with the load edge:
  - The frame loads the old hold.
  - The new pkt_i is captured into hold.
  - pending stays 1.
- Strobe while pending = 1 (including the load-edge case above, where pending was 1 before the edge):
  - hold is overwritten; the newest sample wins.
  - overrun_o pulses on the same edge.
- The arithmetic is pure bit routing; no sign extension or rounding.

## Timing
- All outputs and state are registered on the clk_i rising edge. Downstream samples sd_o/ws_o on the next rising edge.
- Reset values: cnt = 0, ws_o = 0, sd_o = 0, shreg = 0, hold = 0, pending = 0, frameStart_o = 0, underrun_o = 0, overrun_o = 0.
- Reset asserted mid-frame: all state clears immediately (asynchronously); the partial frame is abandoned.
- First edge after reset deassertion:
  - This is a load edge, because cnt = 0.
  - It loads zeros and pulses frameStart_o and underrun_o.
- Latency from strobe to the sample's MSB on sd_o:
  - Minimum 2 cycles (strobe on the edge where cnt goes 31 → 0).
  - Maximum 2·SLOT_WIDTH + 1 cycles (strobe coinciding with a load edge).
- Throughput: one sample per 2·SLOT_WIDTH clocks; 44.1 kHz at the defaults.

## Configuration
- I2S_TX_MUTE_ON_UNDERRUN_EN:
  - Defined: an underrun frame loads all zeros (mute).
  - Undefined: an underrun frame retransmits hold, i.e. repeats the last sample.
- underrun_o pulses in both builds.

## Test plan
- Reset, then a strobe with pkt_i = 16'hA5C3 when cnt = 10:
  - Next frame carries sd_o = A5C3 MSB-first on cnt 1–16 and again on cnt 17–31 plus the next cnt 0.
  - ws_o = 0 on cnt 0–15 and 1 on cnt 16–31.
  - Exactly one underrun_o pulse, after reset.
- Strobe 16'h8001 on the load edge with pending = 0:
  - That frame sends the previous sample, with no overrun_o pulse.
  - The following frame sends 8001.
- Two strobes, 16'h1111 then 16'h2222, within one frame:
  - overrun_o pulses once.
  - The next frame sends 2222.
- No strobes for 3 frames after sending 16'h7FFF:
  - 3 underrun_o pulses.
  - sd_o repeats 7FFF in the default build, or is all-zero with I2S_TX_MUTE_ON_UNDERRUN_EN.
- rst_i asserted at cnt = 20 mid-frame:
  - ws_o and sd_o go to 0 immediately.
  - After release, the first edge is a load edge with frameStart_o = 1.
- SLOT_WIDTH = 24, PKT_WIDTH = 16, sample 16'hFFFF:
  - Each slot shows 16 ones then 8 zeros.
  - Frame period is 48 clocks.
